// File: rtl/demux_1_4_stream_if.sv
// Valid/ready bus bundle for the 1-to-4 streaming demultiplexer.
// master = producer/consumer side, slave = demux side.
interface demux_1_4_stream_if #(
  parameter int unsigned W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// Streaming 1-to-4 demultiplexer: routes each accepted word by in_sel into one
// of four 2-entry FIFOs so a stalled consumer never blocks the other channels.
module demux_1_4_stream #(
  parameter int unsigned W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1_4_stream_if.slave  bus
);
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned SW = 2;

  logic [CW-1:0] count_q [N];
  logic [CW-1:0] count_d [N];
  logic [W-1:0]  head_q  [N];
  logic [W-1:0]  head_d  [N];
  logic [W-1:0]  tail_q  [N];
  logic [W-1:0]  tail_d  [N];
  logic [N-1:0]  valid_q;
  logic [N-1:0]  valid_d;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;

  // Backpressure depends only on the selected channel's occupancy.
  assign bus.in_ready = (count_q[bus.in_sel] != CW'(2));

  // Per-channel FIFO next state: head is the presented word, tail the second.
  always_comb begin
    push    = '0;
    pop     = '0;
    valid_d = valid_q;
    for (int i = 0; i < N; i++) begin
      count_d[i] = count_q[i];
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
    end
    for (int i = 0; i < N; i++) begin
      push[i] = bus.in_valid && bus.in_ready && (bus.in_sel == SW'(i));
      pop[i]  = valid_q[i] && bus.out_ready[i];
      case ({push[i], pop[i]})
        2'b10: begin
          if (count_q[i] == CW'(0)) head_d[i] = bus.in_data;
          else                      tail_d[i] = bus.in_data;
          count_d[i] = count_q[i] + CW'(1);
        end
        2'b01: begin
          head_d[i]  = tail_q[i];
          count_d[i] = count_q[i] - CW'(1);
        end
        // Only reachable at count 1: the new word replaces the departing head.
        2'b11: head_d[i] = bus.in_data;
        default: ;
      endcase
      valid_d[i] = (count_d[i] != CW'(0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        count_q[i] <= '0;
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < N; i++) begin
        count_q[i] <= count_d[i];
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
      end
    end
  end

  assign bus.out_valid = valid_q;

  for (genvar g = 0; g < N; g++) begin : g_out
    assign bus.out_data[g*W +: W] = head_q[g];
  end
endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed self-checking bench for demux_1_4_stream (W = 4).
module tb_demux_1_4_stream;
  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  demux_1_4_stream_if #(.W(4)) bus ();

  demux_1_4_stream #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1ns after the edge so registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = s;
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.out_ready = 4'h0;
    tick();
    tick();
    chk("rst_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_data", bus.out_data, 16'h0);
    chk("rst_ready", 16'(bus.in_ready), 16'h1);
    rst_n = 1'b1;

    // Route: one word to each channel on consecutive cycles.
    bus.out_ready = 4'hF;
    drive(1'b1, 4'ha, 2'd0);
    chk("route_rdy0", 16'(bus.in_ready), 16'h1);
    tick();
    chk("route_v0", 16'(bus.out_valid), 16'h1);
    chk("route_d0", 16'(bus.out_data[3:0]), 16'ha);
    drive(1'b1, 4'hb, 2'd1);
    chk("route_rdy1", 16'(bus.in_ready), 16'h1);
    tick();
    chk("route_v1", 16'(bus.out_valid), 16'h2);
    chk("route_d1", 16'(bus.out_data[7:4]), 16'hb);
    drive(1'b1, 4'hc, 2'd2);
    chk("route_rdy2", 16'(bus.in_ready), 16'h1);
    tick();
    chk("route_v2", 16'(bus.out_valid), 16'h4);
    chk("route_d2", 16'(bus.out_data[11:8]), 16'hc);
    drive(1'b1, 4'hd, 2'd3);
    chk("route_rdy3", 16'(bus.in_ready), 16'h1);
    tick();
    chk("route_v3", 16'(bus.out_valid), 16'h8);
    chk("route_d3", 16'(bus.out_data[15:12]), 16'hd);
    drive(1'b0, 4'h0, 2'd0);
    tick();
    chk("route_drain", 16'(bus.out_valid), 16'h0);

    // Full: channel 1 stalled, third push refused until the consumer drains.
    bus.out_ready = 4'hD;
    drive(1'b1, 4'h7, 2'd1);
    chk("full_rdy_a", 16'(bus.in_ready), 16'h1);
    tick();
    chk("full_v_a", 16'(bus.out_valid), 16'h2);
    chk("full_d_a", 16'(bus.out_data[7:4]), 16'h7);
    drive(1'b1, 4'ha, 2'd1);
    chk("full_rdy_b", 16'(bus.in_ready), 16'h1);
    tick();
    drive(1'b1, 4'h3, 2'd1);
    chk("full_rdy_c", 16'(bus.in_ready), 16'h0);
    tick();
    chk("full_hold_d", 16'(bus.out_data[7:4]), 16'h7);
    chk("full_hold_rdy", 16'(bus.in_ready), 16'h0);
    bus.out_ready = 4'hF;
    #1;
    chk("full_rdy_indep", 16'(bus.in_ready), 16'h0);
    tick();
    chk("full_pop1_d", 16'(bus.out_data[7:4]), 16'ha);
    chk("full_pop1_rdy", 16'(bus.in_ready), 16'h1);
    tick();
    chk("full_pop2_v", 16'(bus.out_valid), 16'h2);
    chk("full_pop2_d", 16'(bus.out_data[7:4]), 16'h3);
    drive(1'b0, 4'h0, 2'd0);
    tick();
    chk("full_drain", 16'(bus.out_valid), 16'h0);

    // Isolation: channel 0 full and stalled, channel 3 still flows.
    bus.out_ready = 4'hE;
    drive(1'b1, 4'h1, 2'd0);
    tick();
    drive(1'b1, 4'h2, 2'd0);
    tick();
    drive(1'b1, 4'h5, 2'd3);
    chk("iso_rdy3", 16'(bus.in_ready), 16'h1);
    tick();
    chk("iso_v", 16'(bus.out_valid), 16'h9);
    chk("iso_d3", 16'(bus.out_data[15:12]), 16'h5);
    chk("iso_d0", 16'(bus.out_data[3:0]), 16'h1);
    drive(1'b0, 4'h0, 2'd0);
    chk("iso_rdy0_full", 16'(bus.in_ready), 16'h0);
    tick();
    chk("iso_v_after", 16'(bus.out_valid), 16'h1);

    // Push+pop at count 1 on channel 2.
    bus.out_ready = 4'hA;
    drive(1'b1, 4'h1, 2'd2);
    tick();
    chk("pp_v_pre", 16'(bus.out_valid), 16'h5);
    bus.out_ready = 4'hE;
    drive(1'b1, 4'h2, 2'd2);
    chk("pp_rdy", 16'(bus.in_ready), 16'h1);
    tick();
    chk("pp_v", 16'(bus.out_valid), 16'h5);
    chk("pp_d2", 16'(bus.out_data[11:8]), 16'h2);
    bus.out_ready = 4'hA;
    drive(1'b0, 4'h0, 2'd2);
    chk("pp_cnt1_rdy", 16'(bus.in_ready), 16'h1);
    tick();
    chk("pp_hold_v", 16'(bus.out_valid), 16'h5);

    // X tolerance: idle bus with unknown data/sel leaves state untouched.
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
    bus.in_sel   = 'x;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("x_valid", 16'(bus.out_valid), 16'h5);
    end
    chk("x_d0", 16'(bus.out_data[3:0]), 16'h1);
    chk("x_d2", 16'(bus.out_data[11:8]), 16'h2);

    // Mid-stream reset with channel 2 full.
    drive(1'b1, 4'h9, 2'd2);
    chk("rst2_rdy_pre", 16'(bus.in_ready), 16'h1);
    tick();
    drive(1'b0, 4'h0, 2'd2);
    chk("rst2_full", 16'(bus.in_ready), 16'h0);
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", 16'(bus.out_valid), 16'h0);
    chk("rst2_data", bus.out_data, 16'h0);
    chk("rst2_rdy", 16'(bus.in_ready), 16'h1);
    rst_n = 1'b1;
    tick();
    bus.out_ready = 4'h0;
    drive(1'b1, 4'h6, 2'd2);
    chk("rst2_push_a", 16'(bus.in_ready), 16'h1);
    tick();
    chk("rst2_v_a", 16'(bus.out_valid), 16'h4);
    chk("rst2_d_a", 16'(bus.out_data[11:8]), 16'h6);
    drive(1'b1, 4'h8, 2'd2);
    chk("rst2_push_b", 16'(bus.in_ready), 16'h1);
    tick();
    drive(1'b1, 4'h4, 2'd2);
    chk("rst2_push_c", 16'(bus.in_ready), 16'h0);
    drive(1'b0, 4'h0, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
